// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART byte-stream deframer.
//   frx_state_t : deframer FSM state encoding
//   SOF_DEFAULT : default start-of-frame delimiter
//   CHK_W       : checksum width (8-bit modular sum)
//   TMO_W       : inter-byte timeout counter width
//   chk_add()   : modular checksum accumulate
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHK     = 3'd3,
        ST_FLUSH   = 3'd4
    } frx_state_t;

    localparam logic [7:0] SOF_DEFAULT = 8'h7E;
    localparam int         CHK_W       = 8;
    localparam int         TMO_W       = 24;

    // Wrapping add; the frame is good when LEN + payload + CHK sums to zero.
    function automatic logic [CHK_W-1:0] chk_add(input logic [CHK_W-1:0] acc,
                                                 input logic [7:0]       data);
        return acc + data;
    endfunction

endpackage

// File: rtl/uart_frame_rx.sv
// -----------------------------------------------------------------------------
// uart_frame_rx
// Deframes a received byte stream of the form SOF, LEN, LEN payload bytes, CHK
// and forwards the payload on an AXI4-Stream master with tlast on the final
// byte and tuser flagging a bad frame. Checks length and checksum, enforces an
// inter-byte timeout and raises one-cycle status pulses per frame.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   s_axis_tdata/tvalid/tready      received byte stream (slave)
//   line_error                      UART framing error pulse
//   m_axis_tdata/tvalid/tready      payload stream (master)
//   m_axis_tlast, m_axis_tuser      end of frame, frame bad (valid with tlast)
//   busy                            FSM not idle
//   frame_ok, crc_error,
//   len_error, timeout_error        one-cycle status pulses
//
// State table:
//   state      | meaning
//   ST_IDLE    | hunting for SOF, other bytes dropped
//   ST_LEN     | expecting the LEN byte
//   ST_PAYLOAD | receiving payload; each byte parks in hold one byte
//   ST_CHK     | expecting the checksum byte; releases held byte as last
//   ST_FLUSH   | frame aborted, waiting to emit held byte as bad last
// -----------------------------------------------------------------------------
module uart_frame_rx
    import uart_pkg::*;
#(
    parameter logic [7:0] SOF_BYTE       = SOF_DEFAULT,
    parameter int         MAX_LEN        = 255,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       line_error,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       m_axis_tlast,
    output logic       m_axis_tuser,
    output logic       busy,
    output logic       frame_ok,
    output logic       crc_error,
    output logic       len_error,
    output logic       timeout_error
);

    localparam logic [8:0]       MAX_LEN_9 = 9'(MAX_LEN);
    localparam bit               TMO_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

    frx_state_t       state, state_nxt;
    logic [CHK_W-1:0] sum, sum_nxt;
    logic [7:0]       remaining, rem_nxt;
    logic [7:0]       hold_data;
    logic             hold_valid;
    logic [TMO_W-1:0] tmo_cnt;

    logic acc, ofree, in_frame, abort_evt, len_bad;
    logic emit, emit_last, emit_user, hold_load, hold_clr;
    logic ok_nxt, crc_nxt, len_nxt, tmo_nxt;
    logic [CHK_W-1:0] sum_chk;

    assign ofree     = !m_axis_tvalid || m_axis_tready;
    assign acc       = s_axis_tvalid && s_axis_tready;
    assign in_frame  = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CHK);
    assign abort_evt = in_frame && (line_error || (TMO_EN && (tmo_cnt == TMO_LAST)));
    assign len_bad   = (s_axis_tdata == 8'd0) || ({1'b0, s_axis_tdata} > MAX_LEN_9);
    assign busy      = (state != ST_IDLE);

    // A payload byte may only be taken when the held byte has somewhere to go.
    always_comb begin
        s_axis_tready = 1'b0;
        case (state)
            ST_IDLE, ST_LEN:     s_axis_tready = 1'b1;
            ST_PAYLOAD, ST_CHK:  s_axis_tready = !hold_valid || ofree;
            default:             s_axis_tready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sum_nxt   = sum;
        rem_nxt   = remaining;
        emit      = 1'b0;
        emit_last = 1'b0;
        emit_user = 1'b0;
        hold_load = 1'b0;
        hold_clr  = 1'b0;
        ok_nxt    = 1'b0;
        crc_nxt   = 1'b0;
        len_nxt   = 1'b0;
        tmo_nxt   = 1'b0;
        sum_chk   = chk_add(sum, s_axis_tdata);

        // Abort wins over any byte accepted in the same cycle; that byte is lost.
        if (abort_evt) begin
            tmo_nxt   = 1'b1;
            state_nxt = ST_IDLE;
            if (hold_valid) begin
                if (ofree) begin
                    emit      = 1'b1;
                    emit_last = 1'b1;
                    emit_user = 1'b1;
                    hold_clr  = 1'b1;
                end else begin
                    state_nxt = ST_FLUSH;
                end
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    sum_nxt = '0;
                    if (acc && (s_axis_tdata == SOF_BYTE)) begin
                        state_nxt = ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (acc) begin
                        if (len_bad) begin
                            len_nxt   = 1'b1;
                            state_nxt = ST_IDLE;
                        end else begin
                            rem_nxt   = s_axis_tdata;
                            sum_nxt   = s_axis_tdata;
                            state_nxt = ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (acc) begin
                        sum_nxt   = sum_chk;
                        rem_nxt   = remaining - 8'd1;
                        emit      = hold_valid;
                        hold_load = 1'b1;
                        if (remaining == 8'd1) begin
                            state_nxt = ST_CHK;
                        end
                    end
                end
                ST_CHK: begin
                    if (acc) begin
                        emit      = 1'b1;
                        emit_last = 1'b1;
                        emit_user = (sum_chk != '0);
                        hold_clr  = 1'b1;
                        ok_nxt    = (sum_chk == '0);
                        crc_nxt   = (sum_chk != '0);
                        state_nxt = ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    if (ofree) begin
                        emit      = 1'b1;
                        emit_last = 1'b1;
                        emit_user = 1'b1;
                        hold_clr  = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum       <= '0;
            remaining <= '0;
        end else begin
            sum       <= sum_nxt;
            remaining <= rem_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data  <= '0;
            hold_valid <= 1'b0;
        end else if (hold_load) begin
            hold_data  <= s_axis_tdata;
            hold_valid <= 1'b1;
        end else if (hold_clr) begin
            hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
        end else if (emit) begin
            m_axis_tdata  <= hold_data;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= emit_last;
            m_axis_tuser  <= emit_user;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
        end
    end

    // Idle time between bytes; a byte stalled by backpressure still has
    // tvalid high, so it never counts toward the timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (acc || !in_frame) begin
            tmo_cnt <= '0;
        end else if (!s_axis_tvalid) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_ok      <= 1'b0;
            crc_error     <= 1'b0;
            len_error     <= 1'b0;
            timeout_error <= 1'b0;
        end else begin
            frame_ok      <= ok_nxt;
            crc_error     <= crc_nxt;
            len_error     <= len_nxt;
            timeout_error <= tmo_nxt;
        end
    end

endmodule
